// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants: opcodes, the M-extension funct7 and register-field positions.
package riscv_pkg;

  localparam int OPC_W = 7;
  localparam int REG_W = 5;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam int OPC_LSB    = 0;
  localparam int RD_LSB     = 7;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

endpackage

// File: rtl/src_use_decode.sv
// Classifies an instruction by which source registers it reads and whether it
// produces a multi-cycle result (load or M-extension op). Purely combinational.
module src_use_decode
  import riscv_pkg::*;
(
  input  logic [31:0] ins,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        is_load,
  output logic        is_mul
);

  logic [OPC_W-1:0] opcode;
  logic [6:0]       funct7;
  logic             unused_fields;

  assign opcode        = ins[OPC_LSB +: OPC_W];
  assign funct7        = ins[FUNCT7_LSB +: 7];
  assign unused_fields = ^ins[FUNCT7_LSB-1:OPC_W];

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
        uses_rs1 = 1'b1;
      end
      OPC_BRANCH, OPC_OP, OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  assign is_load = (opcode == OPC_LOAD);
  assign is_mul  = (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write countdowns that stall the decode instruction until
// every source it reads can be forwarded; also counts hazard-stall cycles.
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int MUL_LAT  = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_ins,
  input  logic             id_valid,
  input  logic             flush,
  input  logic             ext_stall,
  output logic             load_use_stall,
  output logic             issue,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int MAX_LAT = (LOAD_LAT > MUL_LAT) ? LOAD_LAT : MUL_LAT;
  localparam int PEND_W  = $clog2(MAX_LAT + 1);

  localparam logic [PEND_W-1:0] LOAD_SET = PEND_W'(LOAD_LAT);
  localparam logic [PEND_W-1:0] MUL_SET  = PEND_W'(MUL_LAT);
  localparam bit                MUL_EN   = (MUL_LAT > 0);

  logic [PEND_W-1:0] cnt [1:31];
  logic [31:0]       busy_vec;
  logic [REG_W-1:0]  rs1, rs2, rd;
  logic              uses_rs1, uses_rs2, is_load, is_mul;
  logic              live, rs1_hit, rs2_hit, set_load, set_mul;

  src_use_decode u_decode (
    .ins      (id_ins),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2),
    .is_load  (is_load),
    .is_mul   (is_mul)
  );

  assign rs1 = id_ins[RS1_LSB +: REG_W];
  assign rs2 = id_ins[RS2_LSB +: REG_W];
  assign rd  = id_ins[RD_LSB +: REG_W];

  // x0 is never pending, so a zero source field can never produce a hit.
  always_comb begin
    busy_vec = '0;
    for (int r = 1; r < 32; r++) begin
      busy_vec[r] = (cnt[r] != '0);
    end
  end

  // Handshake: decode holds id_ins while load_use_stall is high (a bubble goes to
  // EX); the instruction leaves decode only on a clock edge where issue is high.
  // flush squashes the decode slot (neither stall nor issue); ext_stall freezes
  // everything but still reports the hazard.
  assign rs1_hit        = uses_rs1 & busy_vec[rs1];
  assign rs2_hit        = uses_rs2 & busy_vec[rs2];
  assign live           = id_valid & ~flush & ~rst;
  assign load_use_stall = live & (rs1_hit | rs2_hit);
  assign issue          = live & ~ext_stall & ~load_use_stall;

  // The hazard is judged before rd is set, so a load reading its own rd only
  // waits on an older producer.
  assign set_load = issue & is_load & (rd != '0);
  assign set_mul  = issue & MUL_EN & is_mul & (rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < 32; r++) begin
        cnt[r] <= '0;
      end
    end else if (!ext_stall) begin
      for (int r = 1; r < 32; r++) begin
        if (set_load && rd == REG_W'(r)) begin
          cnt[r] <= LOAD_SET;
        end else if (set_mul && rd == REG_W'(r)) begin
          cnt[r] <= MUL_SET;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (load_use_stall && !ext_stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

  assign busy_mask = busy_vec;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_LAT=1/MUL_LAT=2 and
// LOAD_LAT=3/MUL_LAT=0/CNT_W=4) share one stimulus stream.
module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic [31:0] id_ins;
  logic        id_valid;
  logic        flush;
  logic        ext_stall;

  logic        stall_a, issue_a;
  logic [31:0] busy_a;
  logic [15:0] cyc_a;
  logic        stall_b, issue_b;
  logic [31:0] busy_b;
  logic [3:0]  cyc_b;

  int errors = 0;
  int checks = 0;

  // {dut select (0=a, 1=b), expected stall, expected issue}
  logic [2:0] exp_q[$];

  hazard_scoreboard #(.LOAD_LAT(1), .MUL_LAT(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_ins(id_ins), .id_valid(id_valid), .flush(flush),
    .ext_stall(ext_stall), .load_use_stall(stall_a), .issue(issue_a),
    .busy_mask(busy_a), .stall_cycles(cyc_a)
  );

  hazard_scoreboard #(.LOAD_LAT(3), .MUL_LAT(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .id_ins(id_ins), .id_valid(id_valid), .flush(flush),
    .ext_stall(ext_stall), .load_use_stall(stall_b), .issue(issue_b),
    .busy_mask(busy_b), .stall_cycles(cyc_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_load(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_op(input logic [6:0] f7, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_store(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_branch(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction

  function automatic logic [31:0] enc_jal8(input logic [4:0] rd);
    return {1'b0, 10'd4, 1'b0, 8'd0, rd, 7'b1101111};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1; id_valid = 1'b0; flush = 1'b0; ext_stall = 1'b0; id_ins = 32'h0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One decode cycle: apply inputs at negedge, queue the expected handshake,
  // return 1 time unit after the following posedge.
  task automatic drive(input logic [31:0] ins, input logic valid, input logic fl,
                       input logic ext, input logic sel,
                       input logic exp_stall, input logic exp_issue);
    @(negedge clk);
    id_ins = ins; id_valid = valid; flush = fl; ext_stall = ext;
    exp_q.push_back({sel, exp_stall, exp_issue});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- scoreboard ----------------
  always begin
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      logic [2:0] e;
      logic [1:0] got;
      e = exp_q.pop_front();
      got = e[2] ? {stall_b, issue_b} : {stall_a, issue_a};
      checks++;
      if (got !== e[1:0]) begin
        errors++;
        $display("FAIL handshake dut_%s t=%0t: stall/issue got %b%b want %b%b",
                 e[2] ? "b" : "a", $time, got[1], got[0], e[1], e[0]);
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; id_valid = 1'b1; flush = 1'b0; ext_stall = 1'b0;
    id_ins = enc_op(7'd0, 5'd6, 5'd5, 5'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({stall_a, issue_a, stall_b, issue_b} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %b%b%b%b want 0000",
                 i, stall_a, issue_a, stall_b, issue_b);
      end
      @(posedge clk);
      #1;
      checks++;
      if (busy_a !== 32'h0 || busy_b !== 32'h0 || cyc_a !== 16'd0 || cyc_b !== 4'd0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: busy_a=%h busy_b=%h cyc_a=%0d cyc_b=%0d want all 0",
                 i, busy_a, busy_b, cyc_a, cyc_b);
      end
      @(negedge clk);
    end
    rst = 1'b0; id_valid = 1'b0;
  endtask

  task automatic test_load_lat1();
    apply_reset(1);
    drive(enc_load(5'd5, 5'd1), 1, 0, 0, 0, 0, 1);
    checks++;
    if (busy_a !== 32'h0000_0020) begin
      errors++;
      $display("FAIL lat1_busy_after_load: got %h want 00000020", busy_a);
    end
    drive(enc_op(7'd0, 5'd6, 5'd5, 5'd2), 1, 0, 0, 0, 1, 0);
    checks++;
    if (busy_a !== 32'h0 || cyc_a !== 16'd1) begin
      errors++;
      $display("FAIL lat1_after_bubble: busy=%h cyc=%0d want 0 and 1", busy_a, cyc_a);
    end
    drive(enc_op(7'd0, 5'd6, 5'd5, 5'd2), 1, 0, 0, 0, 0, 1);
    checks++;
    if (cyc_a !== 16'd1) begin
      errors++;
      $display("FAIL lat1_stall_count: got %0d want 1", cyc_a);
    end
    idle();
  endtask

  task automatic test_load_lat3();
    logic [31:0] sw_ins;
    apply_reset(1);
    sw_ins = enc_store(5'd7, 5'd3);
    drive(enc_load(5'd7, 5'd2), 1, 0, 0, 1, 0, 1);
    checks++;
    if (busy_b[7] !== 1'b1) begin
      errors++;
      $display("FAIL lat3_busy_after_load: got %b want 1", busy_b[7]);
    end
    for (int i = 0; i < 3; i++) begin
      drive(sw_ins, 1, 0, 0, 1, 1, 0);
      checks++;
      if (busy_b[7] !== (i < 2) || cyc_b !== 4'(i + 1)) begin
        errors++;
        $display("FAIL lat3_stall_%0d: busy7=%b cyc=%0d want %b and %0d",
                 i, busy_b[7], cyc_b, (i < 2), i + 1);
      end
    end
    drive(sw_ins, 1, 0, 0, 1, 0, 1);
    checks++;
    if (cyc_b !== 4'd3) begin
      errors++;
      $display("FAIL lat3_stall_count: got %0d want 3", cyc_b);
    end
    idle();
  endtask

  task automatic test_freeze();
    logic [31:0] add_ins;
    apply_reset(1);
    add_ins = enc_op(7'd0, 5'd6, 5'd5, 5'd2);
    drive(enc_load(5'd5, 5'd1), 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      drive(add_ins, 1, 0, 1, 0, 1, 0);
      checks++;
      if (busy_a[5] !== 1'b1 || cyc_a !== 16'd0) begin
        errors++;
        $display("FAIL freeze_hold_%0d: busy5=%b cyc=%0d want 1 and 0", i, busy_a[5], cyc_a);
      end
    end
    drive(add_ins, 1, 0, 0, 0, 1, 0);
    checks++;
    if (busy_a[5] !== 1'b0 || cyc_a !== 16'd1) begin
      errors++;
      $display("FAIL freeze_release: busy5=%b cyc=%0d want 0 and 1", busy_a[5], cyc_a);
    end
    drive(add_ins, 1, 0, 0, 0, 0, 1);
    idle();
  endtask

  task automatic test_non_users();
    apply_reset(1);
    drive(enc_load(5'd0, 5'd1), 1, 0, 0, 0, 0, 1);
    checks++;
    if (busy_a !== 32'h0) begin
      errors++;
      $display("FAIL x0_load_busy: got %h want 0", busy_a);
    end
    drive(enc_op(7'd0, 5'd6, 5'd0, 5'd0), 1, 0, 0, 0, 0, 1);
    drive(enc_load(5'd5, 5'd1), 1, 0, 0, 0, 0, 1);
    drive(enc_lui(5'd5, 20'd1), 1, 0, 0, 0, 0, 1);
    drive(enc_load(5'd5, 5'd1), 1, 0, 0, 0, 0, 1);
    drive(enc_jal8(5'd1), 1, 0, 0, 0, 0, 1);
    // a load reading its own rd: no stall alone, one bubble behind an older write
    drive(enc_load(5'd9, 5'd9), 1, 0, 0, 0, 0, 1);
    drive(enc_load(5'd9, 5'd9), 1, 0, 0, 0, 1, 0);
    drive(enc_load(5'd9, 5'd9), 1, 0, 0, 0, 0, 1);
    checks++;
    if (cyc_a !== 16'd1) begin
      errors++;
      $display("FAIL non_users_stall_count: got %0d want 1", cyc_a);
    end
    idle();
  endtask

  task automatic test_mul();
    logic [31:0] mul_ins, beq_ins;
    mul_ins = enc_op(7'b0000001, 5'd8, 5'd1, 5'd2);
    beq_ins = enc_branch(5'd8, 5'd0);
    apply_reset(1);
    drive(mul_ins, 1, 0, 0, 0, 0, 1);
    checks++;
    if (busy_a[8] !== 1'b1 || busy_b !== 32'h0) begin
      errors++;
      $display("FAIL mul_busy: busy_a8=%b busy_b=%h want 1 and 0", busy_a[8], busy_b);
    end
    drive(beq_ins, 1, 0, 0, 0, 1, 0);
    drive(beq_ins, 1, 0, 0, 0, 1, 0);
    drive(beq_ins, 1, 0, 0, 0, 0, 1);
    checks++;
    if (cyc_a !== 16'd2) begin
      errors++;
      $display("FAIL mul_stall_count: got %0d want 2", cyc_a);
    end
    apply_reset(1);
    drive(mul_ins, 1, 0, 0, 0, 0, 1);
    drive(beq_ins, 1, 0, 0, 0, 1, 0);
    drive(beq_ins, 1, 1, 0, 0, 0, 0);
    drive(beq_ins, 1, 0, 0, 0, 0, 1);
    checks++;
    if (cyc_a !== 16'd1) begin
      errors++;
      $display("FAIL mul_flush_count: got %0d want 1", cyc_a);
    end
    drive(beq_ins, 1, 0, 0, 1, 0, 1);
    idle();
  endtask

  task automatic test_back_to_back();
    apply_reset(1);
    drive(enc_load(5'd5, 5'd1), 1, 0, 0, 0, 0, 1);
    drive(enc_load(5'd6, 5'd5), 1, 0, 0, 0, 1, 0);
    drive(enc_load(5'd6, 5'd5), 1, 0, 0, 0, 0, 1);
    drive(enc_op(7'd0, 5'd7, 5'd6, 5'd5), 1, 0, 0, 0, 1, 0);
    drive(enc_op(7'd0, 5'd7, 5'd6, 5'd5), 1, 0, 0, 0, 0, 1);
    checks++;
    if (cyc_a !== 16'd2 || busy_a !== 32'h0) begin
      errors++;
      $display("FAIL b2b_final: cyc=%0d busy=%h want 2 and 0", cyc_a, busy_a);
    end
    idle();
  endtask

  task automatic test_saturation();
    int exp_cnt;
    apply_reset(1);
    exp_cnt = 0;
    for (int k = 0; k < 7; k++) begin
      drive(enc_load(5'd7, 5'd2), 1, 0, 0, 1, 0, 1);
      for (int i = 0; i < 3; i++) begin
        drive(enc_store(5'd7, 5'd3), 1, 0, 0, 1, 1, 0);
      end
      drive(enc_store(5'd7, 5'd3), 1, 0, 0, 1, 0, 1);
      exp_cnt = (exp_cnt + 3 > 15) ? 15 : exp_cnt + 3;
      checks++;
      if (cyc_b !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL saturation_round_%0d: got %0d want %0d", k, cyc_b, exp_cnt);
      end
    end
    idle();
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    rst = 1'b1; id_ins = 32'h0; id_valid = 1'b0; flush = 1'b0; ext_stall = 1'b0;
    test_reset();
    test_load_lat1();
    test_load_lat3();
    test_freeze();
    test_non_users();
    test_mul();
    test_back_to_back();
    test_saturation();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
